keypad_entry_display: RTL and testbench

//  Parametrised keypad-entry successor: scans a ROWS x COLS matrix keypad, debounces per scan frame,

---
 rtl/keypad_entry_display.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_keypad_entry_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_display.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_display
// Description : Scans a ROWS x COLS active-low matrix keypad, debounces the
//               whole-frame scan result, rejects multi-key frames, emits one
//               key event per press, shifts key codes into a DIGITS-wide hex
//               buffer (with clear / backspace keys) and multiplexes that
//               buffer onto DIGITS active-low 7-segment digits.
// Ports       : clk_50M   - system clock, rising edge
//               rst       - asynchronous active-high reset
//               col       - column sense, active-low
//               row       - row drive, one-hot active-low
//               seg_led   - segments {dp,g,f,e,d,c,b,a}, active-low
//               seg_sel   - digit select, one-hot active-low
//               key_valid - one-cycle pulse per accepted press
//               key_code  - code of last accepted key (row*COLS+col)
//               digits    - hex buffer, digit 0 = most recent entry
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_display #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 3,
    parameter int DISP_DIV   = 50000,
    parameter int CLR_CODE   = 15,
    parameter int BS_CODE    = 14,
    parameter int BLANK_LZ   = 1
) (
    input  logic                            clk_50M,
    input  logic                            rst,
    input  logic [COLS-1:0]                 col,
    output logic [ROWS-1:0]                 row,
    output logic [7:0]                      seg_led,
    output logic [DIGITS-1:0]               seg_sel,
    output logic                            key_valid,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic [4*DIGITS-1:0]             digits
);

    localparam int KW  = $clog2(ROWS*COLS);
    localparam int DW  = 4*DIGITS;
    localparam int RW  = $clog2(ROWS);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DCW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [3:0]    c_deb    = 4'(DEB_FRAMES);
    localparam logic [KW-1:0] c_clr    = KW'(CLR_CODE);
    localparam logic [KW-1:0] c_bs     = KW'(BS_CODE);
    localparam bit            c_clr_en = (CLR_CODE < ROWS*COLS);
    localparam bit            c_bs_en  = (BS_CODE < ROWS*COLS);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_chk   = 2'd1;
    localparam logic [1:0] c_st_press = 2'd2;
    localparam logic [1:0] c_st_rel   = 2'd3;

    // ------------------------------------------------------------------
    // Row scanning
    // ------------------------------------------------------------------
    logic [SCW-1:0] r_scan_cnt;
    logic [RW-1:0]  r_row_idx;
    logic           w_slot_end;
    logic           w_frame_end;

    assign w_slot_end  = (r_scan_cnt == SCW'(SCAN_DIV-1));
    assign w_frame_end = w_slot_end && (r_row_idx == RW'(ROWS-1));

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_row_idx  <= '0;
        end else if (w_slot_end) begin
            r_scan_cnt <= '0;
            r_row_idx  <= w_frame_end ? '0 : r_row_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign row = ~(ROWS'(1) << r_row_idx);

    // Hits in the currently driven row: count saturates at 2 (ghosting is
    // all that matters beyond one), code is the lowest low column.
    logic [1:0]    w_row_hits;
    logic [KW-1:0] w_row_code;

    always_comb begin
        w_row_hits = 2'd0;
        w_row_code = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (!col[c]) begin
                w_row_code = KW'(int'(r_row_idx)*COLS + c);
                w_row_hits = (w_row_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    // Frame accumulator; the last row's hits are merged combinationally so
    // the complete frame result is available on the frame-end cycle.
    logic [1:0]    r_acc_hits;
    logic [KW-1:0] r_acc_code;
    logic [2:0]    w_sum;
    logic [1:0]    w_tot_hits;
    logic [KW-1:0] w_frame_code;

    assign w_sum        = {1'b0, r_acc_hits} + {1'b0, w_row_hits};
    assign w_tot_hits   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_frame_code = (r_acc_hits != 2'd0) ? r_acc_code : w_row_code;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_acc_hits <= 2'd0;
            r_acc_code <= '0;
        end else if (w_frame_end) begin
            r_acc_hits <= 2'd0;
            r_acc_code <= '0;
        end else if (w_slot_end) begin
            r_acc_hits <= w_tot_hits;
            r_acc_code <= w_frame_code;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM, advanced once per frame end
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [KW-1:0] r_cand;
    logic          r_key_valid;
    logic [KW-1:0] r_key_code;
    logic          w_none;
    logic          w_single;
    logic [3:0]    w_cnt_inc;
    logic          w_cnt_done;

    assign w_none     = (w_tot_hits == 2'd0);
    assign w_single   = (w_tot_hits == 2'd1);
    assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    assign w_cnt_done = (w_cnt_inc >= c_deb);

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_cand      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    c_st_idle: begin
                        if (w_single) begin
                            r_cand <= w_frame_code;
                            if (DEB_FRAMES == 1) begin
                                r_state     <= c_st_press;
                                r_key_valid <= 1'b1;
                                r_key_code  <= w_frame_code;
                            end else begin
                                r_state <= c_st_chk;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    c_st_chk: begin
                        if (w_single && (w_frame_code == r_cand)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_state     <= c_st_press;
                                r_key_valid <= 1'b1;
                                r_key_code  <= r_cand;
                            end
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                    c_st_press: begin
                        // Held keys never auto-repeat; only a release exits.
                        if (w_none) begin
                            if (DEB_FRAMES == 1) begin
                                r_state <= c_st_idle;
                            end else begin
                                r_state <= c_st_rel;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    c_st_rel: begin
                        if (w_none) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_state <= c_st_idle;
                            end
                        end else begin
                            // Release bounce: back to held, no new event.
                            r_state <= c_st_press;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;

    // ------------------------------------------------------------------
    // Entry buffer
    // ------------------------------------------------------------------
    logic [3:0]    w_code4;
    logic [DW-1:0] r_digits;

    generate
        if (KW >= 4) begin : g_code_wide
            assign w_code4 = r_key_code[3:0];
        end else begin : g_code_narrow
            assign w_code4 = {{(4-KW){1'b0}}, r_key_code};
        end
    endgenerate

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
        end else if (r_key_valid) begin
            if (c_clr_en && (r_key_code == c_clr)) begin
                r_digits <= '0;
            end else if (c_bs_en && (r_key_code == c_bs)) begin
                r_digits <= r_digits >> 4;
            end else begin
                r_digits <= (r_digits << 4) | DW'(w_code4);
            end
        end
    end

    assign digits = r_digits;

    // ------------------------------------------------------------------
    // Display multiplexing
    // ------------------------------------------------------------------
    logic [DCW-1:0]    r_disp_cnt;
    logic [DGW-1:0]    r_dig_idx;
    logic [DIGITS-1:0] w_lz;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [DIGITS-1:0] r_seg_sel;
    logic [7:0]        r_seg_led;

    function automatic logic [7:0] f_hex_seg(input logic [3:0] v);
        case (v)
            4'h0: f_hex_seg = 8'hC0;
            4'h1: f_hex_seg = 8'hF9;
            4'h2: f_hex_seg = 8'hA4;
            4'h3: f_hex_seg = 8'hB0;
            4'h4: f_hex_seg = 8'h99;
            4'h5: f_hex_seg = 8'h92;
            4'h6: f_hex_seg = 8'h82;
            4'h7: f_hex_seg = 8'hF8;
            4'h8: f_hex_seg = 8'h80;
            4'h9: f_hex_seg = 8'h90;
            4'hA: f_hex_seg = 8'h88;
            4'hB: f_hex_seg = 8'h83;
            4'hC: f_hex_seg = 8'hC6;
            4'hD: f_hex_seg = 8'hA1;
            4'hE: f_hex_seg = 8'h86;
            default: f_hex_seg = 8'h8E;
        endcase
    endfunction

    // A digit above 0 is a leading zero when it and everything above it is 0.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_lz
            assign w_lz[k] = (k != 0) && (BLANK_LZ != 0) && (r_digits[DW-1:4*k] == '0);
        end
    endgenerate

    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_dig_idx == DGW'(k)) begin
                w_nib   = r_digits[4*k +: 4];
                w_blank = w_lz[k];
            end
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_disp_cnt <= '0;
            r_dig_idx  <= '0;
        end else if (r_disp_cnt == DCW'(DISP_DIV-1)) begin
            r_disp_cnt <= '0;
            r_dig_idx  <= (r_dig_idx == DGW'(DIGITS-1)) ? '0 : r_dig_idx + 1'b1;
        end else begin
            r_disp_cnt <= r_disp_cnt + 1'b1;
        end
    end

    // Select and segments share one register stage so they always agree.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_seg_sel <= ~DIGITS'(1);
            r_seg_led <= 8'hC0;
        end else begin
            r_seg_sel <= ~(DIGITS'(1) << r_dig_idx);
            r_seg_led <= w_blank ? 8'hFF : f_hex_seg(w_nib);
        end
    end

    assign seg_sel = r_seg_sel;
    assign seg_led = r_seg_led;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry_display
// Description : Self-checking bench for keypad_entry_display. A keypad model
//               turns a pressed-key set into column levels; a frame-level
//               reference model predicts events, buffer and display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_display;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int DIGITS     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_FRAMES = 3;
    localparam int DISP_DIV   = 8;
    localparam int FRAME      = ROWS*SCAN_DIV;

    logic        clk_50M = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [7:0]  seg_led;
    logic [3:0]  seg_sel;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;

    logic [15:0] key_mask = 16'h0000;

    keypad_entry_display #(
        .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
        .DEB_FRAMES(DEB_FRAMES), .DISP_DIV(DISP_DIV), .CLR_CODE(15),
        .BS_CODE(14), .BLANK_LZ(1)
    ) dut (
        .clk_50M(clk_50M), .rst(rst), .col(col), .row(row),
        .seg_led(seg_led), .seg_sel(seg_sel), .key_valid(key_valid),
        .key_code(key_code), .digits(digits)
    );

    always #5 clk_50M = ~clk_50M;

    // Passive keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row[r] && key_mask[r*COLS+c]) col[c] = 1'b0;
    end

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int tests = 0;
    int fails = 0;
    int k     = 0;
    int dut_pulses = 0;

    // Reference model state (frame-level view)
    bit          held;
    int          run_key;
    int          run_len;
    int          none_len;
    bit          exp_kv;
    logic [3:0]  m_code;
    logic [15:0] m_digits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        held = 0; run_key = -1; run_len = 0; none_len = 0;
        exp_kv = 0; m_code = 4'd0; m_digits = 16'h0000;
    endtask

    task automatic model_apply(input int code);
        if (code == 15)      m_digits = 16'h0000;
        else if (code == 14) m_digits = m_digits / 16;
        else                 m_digits = 16'((int'(m_digits) * 16 + code) % 65536);
    endtask

    // One frame of the key set: 0 keys = none, 1 key = single, more = reject.
    task automatic model_frame();
        int n;
        int code;
        n = $countones(key_mask);
        code = 0;
        for (int i = 0; i < 16; i++) if (key_mask[i]) code = i;
        if (!held) begin
            if (n == 1) begin
                if (run_len > 0 && code == run_key) run_len++;
                else if (run_len > 0) begin run_len = 0; run_key = -1; end
                else begin run_key = code; run_len = 1; end
                if (run_len >= DEB_FRAMES) begin
                    held = 1; none_len = 0; run_len = 0;
                    exp_kv = 1; m_code = 4'(code);
                end
            end else begin
                run_len = 0; run_key = -1;
            end
        end else begin
            if (n == 0) begin
                none_len++;
                if (none_len >= DEB_FRAMES) begin held = 0; run_len = 0; run_key = -1; end
            end else begin
                none_len = 0;
            end
        end
    endtask

    task automatic step();
        logic [15:0] prev;
        int didx;
        int upper;
        logic [7:0] exp_seg;
        @(posedge clk_50M);
        k++;
        prev = m_digits;
        if (exp_kv) model_apply(int'(m_code));
        exp_kv = 0;
        if (k % FRAME == 0) model_frame();
        @(negedge clk_50M);
        if (key_valid) dut_pulses++;
        check("key_valid", 32'(key_valid), 32'(exp_kv));
        check("key_code", 32'(key_code), 32'(m_code));
        check("digits", 32'(digits), 32'(m_digits));
        check("row", 32'(row), 32'(4'(~(32'd1 << ((k / SCAN_DIV) % ROWS)))));
        didx = (k == 0) ? 0 : ((k - 1) / DISP_DIV) % DIGITS;
        check("seg_sel", 32'(seg_sel), 32'(4'(~(32'd1 << didx))));
        upper = int'(prev) >> (4 * didx);
        exp_seg = (didx > 0 && upper == 0) ? 8'hFF : font[upper % 16];
        check("seg_led", 32'(seg_led), 32'(exp_seg));
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n);
        key_mask = mask;
        repeat (n * FRAME) step();
    endtask

    task automatic press(input int code);
        run_frames(16'(32'd1 << code), 4);
        run_frames(16'h0000, 4);
    endtask

    // Called on a falling edge; holds reset across exactly one rising edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_row", 32'(row), 32'hE);
        check("rst_seg_sel", 32'(seg_sel), 32'hE);
        check("rst_seg_led", 32'(seg_led), 32'hC0);
        @(negedge clk_50M);
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        int p0;
        int sel;
        int a;
        int b;
        key_mask = 16'(32'd1 << 5);
        @(negedge clk_50M);
        do_reset();

        // Steady r1c1 from reset release: one event, no repeat while held.
        p0 = dut_pulses;
        run_frames(16'(32'd1 << 5), 6);
        check("hold_pulses", 32'(dut_pulses - p0), 32'd1);
        check("hold_digits", 32'(digits), 32'h0005);
        run_frames(16'h0000, 4);

        // Sequence 1,2,3,4,7 with full release between.
        p0 = dut_pulses;
        press(1); press(2); press(3); press(4); press(7);
        check("seq_pulses", 32'(dut_pulses - p0), 32'd5);
        check("seq_digits", 32'(digits), 32'h2347);

        // Clear, rebuild 0347, then backspace and clear.
        press(15);
        check("clr_digits", 32'(digits), 32'h0000);
        press(3); press(4); press(7);
        check("pre_bs_digits", 32'(digits), 32'h0347);
        press(14);
        check("bs_digits", 32'(digits), 32'h0034);
        press(15);
        check("clr2_digits", 32'(digits), 32'h0000);
        run_frames(16'h0000, 3);

        // Bounce: 2 present, 1 absent, 3 present -> exactly one event.
        p0 = dut_pulses;
        run_frames(16'(32'd1 << 9), 2);
        run_frames(16'h0000, 1);
        check("bounce_early", 32'(dut_pulses - p0), 32'd0);
        run_frames(16'(32'd1 << 9), 3);
        check("bounce_pulses", 32'(dut_pulses - p0), 32'd1);
        run_frames(16'h0000, 4);

        // Two keys together are rejected every frame.
        p0 = dut_pulses;
        run_frames(16'(32'd1 << 1) | 16'(32'd1 << 11), 6);
        check("multi_pulses", 32'(dut_pulses - p0), 32'd0);
        check("multi_digits", 32'(digits), 32'h0009);
        run_frames(16'h0000, 4);

        // Reset in the middle of qualification with the key still held.
        key_mask = 16'(32'd1 << 5);
        repeat (2 * FRAME + 5) step();
        do_reset();
        p0 = dut_pulses;
        run_frames(16'(32'd1 << 5), 2);
        check("rst_requal_early", 32'(dut_pulses - p0), 32'd0);
        run_frames(16'(32'd1 << 5), 2);
        check("rst_requal_pulses", 32'(dut_pulses - p0), 32'd1);
        check("rst_requal_digits", 32'(digits), 32'h0005);
        run_frames(16'h0000, 4);

        // Randomized key activity against the reference model.
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                key_mask = 16'h0000;
            end else if (sel < 8) begin
                key_mask = 16'(32'd1 << $urandom_range(0, 15));
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                key_mask = 16'(32'd1 << a) | 16'(32'd1 << b);
            end
            repeat ($urandom_range(1, 5) * FRAME) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
